regfile_read_port: RTL and testbench
====================================

# regfile_read_port

Registered dual-operand read port for the 32 x 64-bit ARM register file. It accepts a source-register request (Rn, Rm) through a valid/ready handshake and returns both operands one cycle later through an output valid/ready handshake. Write-port data is forwarded into the read, and held operands stay coherent with writes that occur while the consumer stalls. It sits between the register file storage and the register-fetch/decode pipeline stage, as the read-side counterpart of the register write path.

## Interface
Parameters:
- none (fixed 32 registers x 64 bits; X31 reads as zero)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- regs_flat  in  2048  current register contents; register i at bits [64i+63:64i]
- wr_en  in  1  register-file write enable for this cycle (commits at next edge)
- wr_addr  in  5  register being written
- wr_data  in  64  data being written
- req_valid  in  1  read request present
- req_ready  out  1  port can accept a request this cycle
- Rn  in  5  first source register
- Rm  in  5  second source register
- rd_valid  out  1  Da/Db hold a valid result
- rd_ready  in  1  consumer accepts the result this cycle
- Da  out  64  operand for Rn
- Db  out  64  operand for Rm

## Operation
- State: one output slot {rd_valid, held_Rn, held_Rm, Da, Db}; states EMPTY (rd_valid=0) and FULL (rd_valid=1).
- req_ready = !rd_valid || rd_ready (combinational, no dependence on req_valid).
- Accept: req_valid && req_ready at an edge → slot loads Rn/Rm, operand values, and rd_valid=1.
- Operand value, per source s in {Rn, Rm}:
  - s == 31 → 64'h0 (regardless of wr_en/wr_addr).
  - else if wr_en && wr_addr == s → wr_data (write-before-read forwarding).
  - else → regs_flat[64s+63:64s].
- Rn and Rm may be equal; both get the identical value.
- Drain: rd_valid && rd_ready && !(req_valid) → rd_valid=0 at edge; Da/Db/held addresses keep last values.
- Simultaneous drain and accept → slot reloads with the new request; rd_valid stays 1 (full throughput, one result per cycle).
- Stall coherence: in FULL with no reload this edge, if wr_en && wr_addr == held_Rn && held_Rn != 31 → Da ← wr_data; likewise Db for held_Rm. Both update if both match.
- wr_addr == 31 has no effect on any output.
- Transitions: EMPTY→FULL on accept; FULL→FULL on stall or drain+accept; FULL→EMPTY on drain without accept.

## Timing
- Latency: request accepted at edge N → Da/Db/rd_valid visible after edge N, consumable at edge N+1.
- Operands reflect regs_flat and wr_* sampled at the accepting edge, not later.
- Stall-coherence write at edge M visible on Da/Db after edge M.
- Reset (reset low, asynchronous): rd_valid=0, Da=0, Db=0, held_Rn=held_Rm=0 immediately; req_ready=1 while in reset. Reset mid-transfer discards the held result; no result is emitted after deassertion until a new accept.
- Reset deassertion is synchronized externally; the first edge after deassertion can accept.
- No combinational path from req_valid/Rn/Rm to Da/Db/rd_valid; only rd_ready → req_ready is combinational.

## Test plan
- Basic read: regs X3=64'h1111, X7=64'h2222; request Rn=3, Rm=7 → after one edge rd_valid=1, Da=64'h1111, Db=64'h2222.
- Zero register and forwarding: Rn=31, Rm=5 with wr_en=1, wr_addr=5, wr_data=64'hDEAD, regs X5=64'h0 → Da=0, Db=64'hDEAD; repeat with wr_addr=31, Rn=31 → Da=0.
- Back-to-back: rd_ready=1, three consecutive requests (1,2),(3,4),(5,6) → three consecutive results, req_ready=1 every cycle, no bubbles.
- Stall coherence: accept Rn=9, Rm=9 (X9=64'hA), hold rd_ready=0; write X9=64'hB → next cycle Da=Db=64'hB, req_ready=0; then rd_ready=1 with req_valid=0 → rd_valid=0 after edge.
- Reset mid-operation: FULL with Da=64'h1234, assert reset asynchronously between edges → rd_valid=0, Da=Db=0 before next edge; after release, no rd_valid until a new request.
- Random check: 10k random requests/writes/rd_ready stalls against a reference register model → every accepted result matches model value at accept time, adjusted by in-stall writes.

Source files
------------

// File: rtl/regfile_read_port.sv
// Registered dual-operand read port for the 32 x 64-bit register file.
// Latency: one cycle. A request accepted at edge N is presented on Da/Db after edge N.
// Backpressure: single output slot. req_ready = !rd_valid || rd_ready, so a drain and a new accept can share one edge.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   regs_flat       current register contents, register i at [64i+63:64i]
//   wr_en/addr/data write port activity this cycle (commits at the next edge)
//   req_valid/ready request handshake carrying Rn, Rm
//   rd_valid/ready  result handshake carrying Da (for Rn) and Db (for Rm)
module regfile_read_port (
   input  logic          clk,
   input  logic          reset,
   input  logic [2047:0] regs_flat,
   input  logic          wr_en,
   input  logic [4:0]    wr_addr,
   input  logic [63:0]   wr_data,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [4:0]    Rn,
   input  logic [4:0]    Rm,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [63:0]   Da,
   output logic [63:0]   Db
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state;
   logic [4:0]  held_rn;
   logic [4:0]  held_rm;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        accept;

   assign rd_valid  = (state == FULL);
   assign req_ready = (state == EMPTY) || rd_ready;
   assign accept    = req_valid && req_ready;

   // Operand selection: X31 is hard zero, then a same-cycle write is
   // forwarded ahead of the (not yet updated) storage contents.
   always_comb begin
      op_a = regs_flat[{Rn, 6'd0} +: 64];
      op_b = regs_flat[{Rm, 6'd0} +: 64];
      if (wr_en && (wr_addr == Rn)) op_a = wr_data;
      if (wr_en && (wr_addr == Rm)) op_b = wr_data;
      if (Rn == 5'd31) op_a = 64'h0;
      if (Rm == 5'd31) op_b = 64'h0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= EMPTY;
         held_rn <= 5'd0;
         held_rm <= 5'd0;
         Da      <= 64'h0;
         Db      <= 64'h0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state   <= FULL;
                  held_rn <= Rn;
                  held_rm <= Rm;
                  Da      <= op_a;
                  Db      <= op_b;
               end
            end
            FULL: begin
               if (accept) begin
                  // Drain and reload on the same edge: stay FULL.
                  held_rn <= Rn;
                  held_rm <= Rm;
                  Da      <= op_a;
                  Db      <= op_b;
               end else if (rd_ready) begin
                  // Drain only; operand registers keep their last values.
                  state <= EMPTY;
               end else begin
                  // Stalled: track writes to the held registers so the
                  // consumer always sees the architecturally current value.
                  if (wr_en && (wr_addr == held_rn) && (held_rn != 5'd31))
                     Da <= wr_data;
                  if (wr_en && (wr_addr == held_rm) && (held_rm != 5'd31))
                     Db <= wr_data;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios then a long random run.
// The bench owns the register array and commits writes at each edge; while a
// result is held, the expected operand is simply the current register value.
module tb_regfile_read_port;

   logic          clk;
   logic          reset;
   logic [2047:0] regs_flat;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [63:0]   wr_data;
   logic          req_valid;
   logic          req_ready;
   logic [4:0]    Rn;
   logic [4:0]    Rm;
   logic          rd_valid;
   logic          rd_ready;
   logic [63:0]   Da;
   logic [63:0]   Db;

   logic [63:0] regs [32];

   // reference slot state
   bit         exp_valid;
   logic [4:0] exp_rn;
   logic [4:0] exp_rm;

   int checks;
   int failures;

   regfile_read_port dut (
      .clk       (clk),
      .reset     (reset),
      .regs_flat (regs_flat),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .Rn        (Rn),
      .Rm        (Rm),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .Da        (Da),
      .Db        (Db)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 32; i++) regs_flat[i*64 +: 64] = regs[i];
   end

   function automatic logic [63:0] arch_val(input logic [4:0] r);
      return (r == 5'd31) ? 64'h0 : regs[r];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the currently driven inputs, checked against the model.
   task automatic step(input bit full_check);
      bit acc;
      #1;
      acc = req_valid && (!exp_valid || rd_ready);
      if (full_check) chk("req_ready", {63'h0, req_ready}, {63'h0, (!exp_valid || rd_ready)});
      @(posedge clk);
      #1;
      if (wr_en) regs[wr_addr] = wr_data;
      if (acc) begin
         exp_valid = 1'b1;
         exp_rn    = Rn;
         exp_rm    = Rm;
      end else if (exp_valid && rd_ready) begin
         exp_valid = 1'b0;
      end
      if (full_check) begin
         chk("rd_valid", {63'h0, rd_valid}, {63'h0, exp_valid});
         if (exp_valid) begin
            chk("Da_model", Da, arch_val(exp_rn));
            chk("Db_model", Db, arch_val(exp_rm));
         end
      end
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'h0;
      req_valid = 1'b0; Rn = 5'd0; Rm = 5'd0;
   endtask

   initial begin
      checks = 0; failures = 0;
      exp_valid = 1'b0; exp_rn = 5'd0; exp_rm = 5'd0;
      for (int i = 0; i < 32; i++) regs[i] = 64'h0;
      idle_inputs();
      rd_ready = 1'b0;
      reset = 1'b0;

      // reset state
      #3;
      chk("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
      chk("rst_Da", Da, 64'h0);
      chk("rst_Db", Db, 64'h0);
      chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
      @(negedge clk);
      reset = 1'b1;

      // basic read
      regs[3] = 64'h1111; regs[7] = 64'h2222;
      for (int i = 1; i <= 6; i++) if (i != 3) regs[i] = 64'h100 * i;
      req_valid = 1'b1; Rn = 5'd3; Rm = 5'd7; rd_ready = 1'b0;
      step(1);
      chk("basic_valid", {63'h0, rd_valid}, 64'h1);
      chk("basic_Da", Da, 64'h1111);
      chk("basic_Db", Db, 64'h2222);

      // zero register and forwarding (drain + accept)
      rd_ready = 1'b1;
      regs[5] = 64'h0;
      Rn = 5'd31; Rm = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
      step(1);
      chk("zero_Da", Da, 64'h0);
      chk("fwd_Db", Db, 64'hDEAD);
      wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF; Rn = 5'd31; Rm = 5'd31;
      step(1);
      chk("wr31_Da", Da, 64'h0);
      chk("wr31_Db", Db, 64'h0);
      wr_en = 1'b0;

      // back-to-back
      regs[1] = 64'h100; regs[2] = 64'h200; regs[3] = 64'h300;
      regs[4] = 64'h400; regs[5] = 64'h500; regs[6] = 64'h600;
      for (int k = 0; k < 3; k++) begin
         Rn = 5'(2*k + 1); Rm = 5'(2*k + 2);
         step(1);
         chk("b2b_valid", {63'h0, rd_valid}, 64'h1);
         chk("b2b_Da", Da, 64'h100 * (2*k + 1));
         chk("b2b_Db", Db, 64'h100 * (2*k + 2));
      end

      // stall coherence
      regs[9] = 64'hA;
      Rn = 5'd9; Rm = 5'd9; rd_ready = 1'b1;
      step(1);
      chk("stall_Da0", Da, 64'hA);
      rd_ready = 1'b0; req_valid = 1'b1; Rn = 5'd1; Rm = 5'd2;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hB;
      step(1);
      chk("stall_Da", Da, 64'hB);
      chk("stall_Db", Db, 64'hB);
      chk("stall_req_ready", {63'h0, req_ready}, 64'h0);
      wr_en = 1'b0; req_valid = 1'b0; rd_ready = 1'b1;
      step(1);
      chk("drain_valid", {63'h0, rd_valid}, 64'h0);

      // reset mid-operation
      regs[4] = 64'h1234;
      req_valid = 1'b1; Rn = 5'd4; Rm = 5'd4; rd_ready = 1'b0;
      step(1);
      chk("pre_rst_Da", Da, 64'h1234);
      req_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", {63'h0, rd_valid}, 64'h0);
      chk("arst_Da", Da, 64'h0);
      chk("arst_Db", Db, 64'h0);
      chk("arst_req_ready", {63'h0, req_ready}, 64'h1);
      exp_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rd_ready = 1'b1;
      step(1);
      step(1);
      chk("post_rst_valid", {63'h0, rd_valid}, 64'h0);

      // random run
      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
      for (int n = 0; n < 10000; n++) begin
         req_valid = ($urandom_range(0, 9) < 7);
         rd_ready  = ($urandom_range(0, 9) < 6);
         Rn        = 5'($urandom_range(0, 31));
         Rm        = ($urandom_range(0, 7) == 0) ? Rn : 5'($urandom_range(0, 31));
         wr_en     = $urandom_range(0, 1) == 1;
         wr_addr   = ($urandom_range(0, 3) == 0) ? Rn : 5'($urandom_range(0, 31));
         if (exp_valid && $urandom_range(0, 3) == 0) wr_addr = exp_rn;
         wr_data   = {$urandom, $urandom};
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
